// File: rtl/cfg_regmap_bank_if.sv
// ---------------------------------------------------------------------------
// cfg_regmap_bank_if
// Bus bundle for the configuration register bank.
//   Write request : wr_cmd, wr_addr, wr_data, wr_keep      (master -> slave)
//   Write status  : wr_ready, wr_valid, wr_err             (slave -> master)
//   Read request  : rd_cmd, rd_addr                        (master -> slave)
//   Read response : rd_data, rd_valid, rd_err              (slave -> master)
// ---------------------------------------------------------------------------
interface cfg_regmap_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_keep;
  logic              wr_ready;
  logic              wr_valid;
  logic [1:0]        wr_err;
  logic              rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (
    output wr_cmd, wr_addr, wr_data, wr_keep, rd_cmd, rd_addr,
    input  wr_ready, wr_valid, wr_err, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_cmd, wr_addr, wr_data, wr_keep, rd_cmd, rd_addr,
    output wr_ready, wr_valid, wr_err, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/cfg_regmap_bank.sv
// ---------------------------------------------------------------------------
// cfg_regmap_bank
// Configuration register bank with masked writes, error reporting and
// optional shadow/commit double-buffering. Register 0 is a read-only
// VERSION register.
//
// Optional feature macro: CFG_REGMAP_SHADOW_EN
//   defined   : writes land in shadow registers, commit_strobe copies them
//               to the active set that drives cfg_regs.
//   undefined : writes land directly in the active set, commit_strobe is
//               ignored and commit_pending stays 0.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   bus (slave)     : write/read bus, see cfg_regmap_bank_if
//   commit_strobe   : shadow -> active transfer request
//   commit_pending  : shadow contents differ from last commit
//   cfg_regs        : flattened active registers, reg i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module cfg_regmap_bank #(
  parameter int                           DATA_W     = 32,
  parameter int                           ADDR_W     = 8,
  parameter int                           NUM_REGS   = 16,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALS = '0,
  parameter logic [31:0]                  VERSION    = 32'h0001_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cfg_regmap_bank_if.slave             bus,
  input  logic                         commit_strobe,
  output logic                         commit_pending,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_regs
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
  localparam logic [DATA_W-1:0] VERSION_L  = DATA_W'(VERSION);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_keep_q;
  logic              wr_ready_q;
  logic              wr_valid_q;
  logic [1:0]        wr_err_q;
  logic              rd_valid_q;
  logic              rd_err_q;
  logic [DATA_W-1:0] rd_data_q;

  // Registers written by the bus: shadow set with the feature, active set without.
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  logic [1:0]        wr_code_s;
  logic              wr_do_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_new_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              rd_oor_s;
  logic [DATA_W-1:0] rd_val_s;

  assign wr_idx_s = wr_addr_q[IDX_W-1:0];
  assign rd_idx_s = bus.rd_addr[IDX_W-1:0];
  assign rd_oor_s = ({1'b0, bus.rd_addr} >= NUM_REGS_L);
  assign wr_new_s = (shadow_q[wr_idx_s] & ~wr_keep_q) | (wr_data_q & wr_keep_q);
  assign wr_do_s  = (state_q == ST_CHECK) && (wr_code_s == 2'b00);

  // Classify the latched write; range beats read-only beats empty mask.
  always_comb begin
    wr_code_s = 2'b00;
    if ({1'b0, wr_addr_q} >= NUM_REGS_L) begin
      wr_code_s = 2'b11;
    end else if (wr_addr_q == '0) begin
      wr_code_s = 2'b01;
    end else if (wr_keep_q == '0) begin
      wr_code_s = 2'b10;
    end else begin
      wr_code_s = 2'b00;
    end
  end

  // Write FSM next state: one accept cycle, then CHECK and RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = bus.wr_cmd ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write FSM state, request latch and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ready_q <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_err_q   <= 2'b00;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_keep_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ready_q <= (state_d == ST_IDLE);
      // Response is registered on the CHECK edge so it is visible during RESP only.
      wr_valid_q <= wr_do_s;
      wr_err_q   <= (state_q == ST_CHECK) ? wr_code_s : 2'b00;
      if ((state_q == ST_IDLE) && bus.wr_cmd) begin
        wr_addr_q <= bus.wr_addr;
        wr_data_q <= bus.wr_data;
        wr_keep_q <= bus.wr_keep;
      end
    end
  end

  // Bus-writable register storage with masked update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
    end else if (wr_do_s) begin
      shadow_q[wr_idx_s] <= wr_new_s;
    end
  end

  // Read data selection; register 0 always reports VERSION.
  always_comb begin
    rd_val_s = '0;
    if (rd_oor_s) begin
      rd_val_s = '0;
    end else if (bus.rd_addr == '0) begin
      rd_val_s = VERSION_L;
    end else begin
      rd_val_s = shadow_q[rd_idx_s];
    end
  end

  // Registered read response; sampling before the write edge yields pre-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_cmd;
      rd_err_q   <= bus.rd_cmd & rd_oor_s;
      rd_data_q  <= bus.rd_cmd ? rd_val_s : '0;
    end
  end

`ifdef CFG_REGMAP_SHADOW_EN
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic              commit_pending_q;

  // Active set takes the pre-edge shadow contents on a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
    end else if (commit_strobe) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  // A write coinciding with a commit is not part of it, so pending wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending_q <= 1'b0;
    end else if (wr_do_s) begin
      commit_pending_q <= 1'b1;
    end else if (commit_strobe) begin
      commit_pending_q <= 1'b0;
    end
  end

  assign commit_pending = commit_pending_q;
`else
  logic unused_commit_s;
  assign unused_commit_s = commit_strobe;
  assign commit_pending  = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
    if (gi == 0) begin : g_ver
      assign cfg_regs[gi*DATA_W +: DATA_W] = VERSION_L;
    end else begin : g_reg
`ifdef CFG_REGMAP_SHADOW_EN
      assign cfg_regs[gi*DATA_W +: DATA_W] = active_q[gi];
`else
      assign cfg_regs[gi*DATA_W +: DATA_W] = shadow_q[gi];
`endif
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_cfg_regmap_bank.sv
// ---------------------------------------------------------------------------
// tb_cfg_regmap_bank
// Directed scenarios plus randomized traffic against a transaction-level
// model of the register bank (arrays of register values, a pending flag).
// ---------------------------------------------------------------------------
module tb_cfg_regmap_bank;
  localparam int          NR  = 16;
  localparam logic [31:0] VER = 32'h0001_0000;
  localparam logic [NR*32-1:0] RV = {
    32'hF0F0_0F0F, 32'h0E0E_0E0E, 32'h0D0D_0D0D, 32'h0C0C_0C0C,
    32'h0B0B_0B0B, 32'h0A0A_0A0A, 32'h0909_0909, 32'h0808_0808,
    32'h0707_0707, 32'h0606_0606, 32'h5555_5555, 32'h4444_4444,
    32'd20,        32'hAAAA_AAAA, 32'h1111_1111, 32'hDEAD_BEEF
  };
`ifdef CFG_REGMAP_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             commit_strobe = 1'b0;
  logic             commit_pending;
  logic [NR*32-1:0] cfg_regs;

  cfg_regmap_bank_if #(.DATA_W(32), .ADDR_W(8)) ifc ();

  cfg_regmap_bank #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(NR), .RESET_VALS(RV), .VERSION(VER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .commit_strobe(commit_strobe), .commit_pending(commit_pending),
    .cfg_regs(cfg_regs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bus-visible registers, active registers, pending flag.
  logic [31:0] regs_m [NR];
  logic [31:0] act_m  [NR];
  bit          pend_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      regs_m[i] = RV[i*32 +: 32];
      act_m[i]  = RV[i*32 +: 32];
    end
    pend_m = 1'b0;
  endtask

  function automatic logic [1:0] exp_code(input int a, input logic [31:0] k);
    if (a >= NR)      return 2'b11;
    else if (a == 0)  return 2'b01;
    else if (k == 0)  return 2'b10;
    else              return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a >= NR)     return 32'h0;
    else if (a == 0) return VER;
    else             return regs_m[a];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_cfg%0d", tag, i), cfg_regs[i*32 +: 32], (i == 0) ? VER : act_m[i]);
    end
    chk({tag, "_pending"}, {31'b0, commit_pending}, {31'b0, pend_m});
  endtask

  task automatic do_read(input int a);
    ifc.rd_cmd  = 1'b1;
    ifc.rd_addr = 8'(a);
    @(posedge clk); #1;
    ifc.rd_cmd  = 1'b0;
    ifc.rd_addr = 8'($urandom);
    chk($sformatf("rd_valid_a%0d", a), {31'b0, ifc.rd_valid}, 32'd1);
    chk($sformatf("rd_data_a%0d", a), ifc.rd_data, exp_rd(a));
    chk($sformatf("rd_err_a%0d", a), {31'b0, ifc.rd_err}, (a >= NR) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk("rd_valid_pulse", {31'b0, ifc.rd_valid}, 32'd0);
  endtask

  task automatic do_commit();
    commit_strobe = 1'b1;
    @(posedge clk); #1;
    commit_strobe = 1'b0;
    if (SHADOW) begin
      for (int i = 0; i < NR; i++) act_m[i] = regs_m[i];
      pend_m = 1'b0;
    end
  endtask

  // One write transaction; optionally a commit and a same-register read on the CHECK edge.
  task automatic do_write(input int a, input logic [31:0] d, input logic [31:0] k,
                          input bit strobe, input bit rd_same);
    logic [1:0]  code;
    logic [31:0] old_rd;
    int w = 0;
    while (!ifc.wr_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("wr_ready_wait", {31'b0, ifc.wr_ready}, 32'd1);
    ifc.wr_cmd  = 1'b1;
    ifc.wr_addr = 8'(a);
    ifc.wr_data = d;
    ifc.wr_keep = k;
    @(posedge clk); #1;
    ifc.wr_cmd  = 1'b0;
    ifc.wr_addr = 8'($urandom);
    ifc.wr_data = $urandom;
    ifc.wr_keep = $urandom;
    chk("wr_ready_busy", {31'b0, ifc.wr_ready}, 32'd0);
    chk("wr_valid_early", {31'b0, ifc.wr_valid}, 32'd0);
    code   = exp_code(a, k);
    old_rd = exp_rd(a);
    commit_strobe = strobe;
    if (rd_same) begin
      ifc.rd_cmd  = 1'b1;
      ifc.rd_addr = 8'(a);
    end
    @(posedge clk); #1;
    commit_strobe = 1'b0;
    ifc.rd_cmd    = 1'b0;
    if (SHADOW && strobe) begin
      for (int i = 0; i < NR; i++) act_m[i] = regs_m[i];
      pend_m = 1'b0;
    end
    if (code == 2'b00) begin
      regs_m[a] = (regs_m[a] & ~k) | (d & k);
      if (SHADOW) pend_m = 1'b1;
      else        act_m[a] = regs_m[a];
    end
    chk($sformatf("wr_valid_a%0d", a), {31'b0, ifc.wr_valid}, (code == 2'b00) ? 32'd1 : 32'd0);
    chk($sformatf("wr_err_a%0d", a), {30'b0, ifc.wr_err}, {30'b0, code});
    chk("wr_ready_resp", {31'b0, ifc.wr_ready}, 32'd0);
    if (rd_same) chk($sformatf("rd_prewrite_a%0d", a), ifc.rd_data, old_rd);
    @(posedge clk); #1;
    chk("wr_valid_end", {31'b0, ifc.wr_valid}, 32'd0);
    chk("wr_err_end", {30'b0, ifc.wr_err}, 32'd0);
    chk("wr_ready_end", {31'b0, ifc.wr_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, low, vcnt, op, a;
    logic [31:0] d, k;
    ifc.wr_cmd = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.wr_keep = '0;
    ifc.rd_cmd = 1'b0; ifc.rd_addr = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", {31'b0, ifc.wr_ready}, 32'd1);
    chk("rst_wr_valid", {31'b0, ifc.wr_valid}, 32'd0);
    chk("rst_wr_err", {30'b0, ifc.wr_err}, 32'd0);
    chk("rst_rd_valid", {31'b0, ifc.rd_valid}, 32'd0);
    chk("rst_rd_err", {31'b0, ifc.rd_err}, 32'd0);
    chk("rst_rd_data", ifc.rd_data, 32'd0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reads after reset release, including range and VERSION cases
    do_read(3);
    chk("rd3_const", regs_m[3], 32'd20);
    do_read(0);
    do_read(16);
    do_read(200);

    // Masked write over reset value, commit afterwards
    do_write(2, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b1);
    check_all("w2_precommit");
    do_read(2);
    chk("w2_model", regs_m[2], 32'hAAAA_5678);
    do_commit();
    check_all("w2_commit");

    // Error classes leave registers untouched
    do_write(0, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_write(16, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_write(5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1);
    check_all("errs");
    do_read(5);

    // Commit coinciding with a write to reg 4
    do_write(4, 32'hCAFE_0004, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_all("w4_coinc");
    do_commit();
    check_all("w4_next");

    // wr_cmd held high for 30 cycles
    acc = 0; low = 0; vcnt = 0;
    ifc.wr_cmd = 1'b1; ifc.wr_addr = 8'd7;
    ifc.wr_data = 32'h7777_ABCD; ifc.wr_keep = 32'hFFFF_FFFF;
    for (int c = 0; c < 30; c++) begin
      if (ifc.wr_ready) acc++;
      else              low++;
      @(posedge clk); #1;
      if (ifc.wr_valid) vcnt++;
    end
    ifc.wr_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    regs_m[7] = 32'h7777_ABCD;
    if (SHADOW) pend_m = 1'b1;
    else        act_m[7] = regs_m[7];
    chk("burst_accepted", 32'(acc), 32'd10);
    chk("burst_ready_low", 32'(low), 32'd20);
    chk("burst_valid_pulses", 32'(vcnt), 32'd10);
    check_all("burst");
    do_read(7);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, NR + 3);
      if (op <= 1) begin
        d = $urandom;
        k = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        do_write(a, d, k, 1'($urandom_range(0, 1)), 1'b1);
      end else if (op == 2) begin
        do_read(a);
      end else begin
        do_commit();
      end
      check_all($sformatf("rnd%0d", it));
    end

    // Reset while the write sits in CHECK
    ifc.wr_cmd = 1'b1; ifc.wr_addr = 8'd9;
    ifc.wr_data = 32'h9999_9999; ifc.wr_keep = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ifc.wr_cmd = 1'b0;
    chk("abort_in_check", {31'b0, ifc.wr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("abort_wr_ready", {31'b0, ifc.wr_ready}, 32'd1);
    chk("abort_wr_valid", {31'b0, ifc.wr_valid}, 32'd0);
    chk("abort_wr_err", {30'b0, ifc.wr_err}, 32'd0);
    check_all("abort");
    @(posedge clk); #1;
    chk("abort_wr_valid2", {31'b0, ifc.wr_valid}, 32'd0);
    chk("abort_wr_err2", {30'b0, ifc.wr_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_resp", {31'b0, ifc.wr_valid}, 32'd0);
    do_read(9);
    check_all("abort_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_regmap_bank.md
CFG_REGMAP_BANK -- requirements
Module: cfg_regmap_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and write-data width.
REQ-002 SHALL have parameter ADDR_W, default 8: address width.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of registers; must be 2..2**ADDR_W.
REQ-004 SHALL have parameter RESET_VALS, default all-zero, width NUM_REGS*DATA_W: per-register reset values, where register i occupies bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have parameter VERSION, default 32'h0001_0000: read-only contents of register 0.
REQ-006 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port wr_cmd, input, 1: write request, sampled only while wr_ready=1.
REQ-009 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-010 SHALL have port wr_data, input, DATA_W: write data.
REQ-011 SHALL have port wr_keep, input, DATA_W: per-bit write mask, where 1 means update the bit.
REQ-012 SHALL have port wr_ready, output, 1: the block can accept a write.
REQ-013 SHALL have port wr_valid, output, 1: one-cycle pulse meaning the write succeeded.
REQ-014 SHALL have port wr_err, output, 2: one-cycle error code (00 ok, 01 read-only, 10 zero mask, 11 out of range).
REQ-015 SHALL have port rd_cmd, input, 1: read request, accepted every cycle.
REQ-016 SHALL have port rd_addr, input, ADDR_W: read address.
REQ-017 SHALL have port rd_data, output, DATA_W: read data.
REQ-018 SHALL have port rd_valid, output, 1: one-cycle pulse qualifying rd_data.
REQ-019 SHALL have port rd_err, output, 1: out-of-range read, qualified by rd_valid.
REQ-020 SHALL have port commit_strobe, input, 1: transfers shadow registers to active registers (for example on a PRF tick).
REQ-021 SHALL have port commit_pending, output, 1: the shadow registers differ from the last commit.
REQ-022 SHALL have port cfg_regs, output, NUM_REGS*DATA_W: active register values, flattened as in REQ-004.

Function
REQ-023 SHALL implement a write FSM with states IDLE, CHECK and RESP; wr_ready=1 only in IDLE.
REQ-024 SHALL latch addr, data and keep and move to CHECK when wr_cmd=1 in IDLE at edge k.
REQ-025 SHALL, in CHECK, classify the write with priority: addr>=NUM_REGS gives 11; addr==0 gives 01; keep==0 gives 10; otherwise the write is valid.
REQ-026 SHALL, for a valid write, update shadow[addr] to (shadow & ~keep) | (data & keep) at edge k+1.
REQ-027 SHALL, in RESP, drive wr_valid=1 for success or wr_err=code for failure during the cycle after edge k+1; both outputs are 0 outside RESP.
REQ-028 SHALL return to IDLE at edge k+2, giving a minimum write spacing of 3 cycles.
REQ-029 SHALL ignore wr_cmd outside IDLE; no queuing.
REQ-030 SHALL, when rd_cmd=1 at edge k, register rd_valid=1 and rd_data=shadow[rd_addr] (register 0 returns VERSION) for the cycle after edge k.
REQ-031 SHALL, for an out-of-range read, return rd_data=0 with rd_err=1.
REQ-032 SHALL return pre-write contents when a read hits the register being written in the same cycle.
REQ-033 SHALL set commit_pending on every valid write.
REQ-034 SHALL, on commit_strobe, copy shadow to active and clear commit_pending.
REQ-035 SHALL, when commit_strobe and a shadow write coincide at the same edge, copy pre-write shadow to active and leave commit_pending=1.
REQ-036 SHALL drive cfg_regs register 0 with VERSION at all times.

Reset
REQ-037 SHALL, on rst_n=0, immediately load shadow and active from RESET_VALS, force the FSM to IDLE and set wr_ready=1, wr_valid=0, wr_err=00, rd_valid=0, rd_err=0, rd_data=0 and commit_pending=0.
REQ-038 SHALL, on reset mid-transaction, abort the write with no response and no register update.

Configuration
REQ-039 SHALL implement shadow/commit double-buffering when macro CFG_REGMAP_SHADOW_EN is defined.
REQ-040 SHALL, without CFG_REGMAP_SHADOW_EN, write directly to active, ignore commit_strobe, hold commit_pending=0, and read back active values.

Verification
REQ-041 SHALL cover: reset release, then read addr 3 with RESET_VALS[3]=32'd20 -> rd_data=20 one cycle later, rd_err=0.
REQ-042 SHALL cover: write addr 2, data 32'h1234_5678, keep 32'h0000_FFFF over old 32'hAAAA_AAAA -> wr_valid at k+2, shadow=32'hAAAA_5678, commit_pending=1, cfg_regs unchanged until commit_strobe.
REQ-043 SHALL cover: writes to addr 0, addr 16 (NUM_REGS=16) and addr 5 with keep 0 -> wr_err 01, 11 and 10 respectively, with no register change.
REQ-044 SHALL cover: commit_strobe on the same edge as a valid write to addr 4 -> active reg 4 holds the old value and commit_pending stays 1; the next strobe applies the new value.
REQ-045 SHALL cover: wr_cmd held high continuously for 30 cycles -> exactly 10 writes accepted and wr_ready low 2 of every 3 cycles.
REQ-046 SHALL cover: rst_n asserted in CHECK -> no wr_valid and no wr_err, registers equal RESET_VALS, and wr_ready=1 immediately.
